// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / stall sequencer.
// Holds the FSM state enum, the register-field width and the load-use detect helper.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_e;

  // A load into r0 never creates a dependency, since r0 reads as zero.
  function automatic logic load_use_hit(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] ex_rt,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rt
  );
    return mem_read && (ex_rt != ZERO_REG) && ((ex_rt == rs) || (ex_rt == rt));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard-detect inputs and pipeline-control outputs between the datapath and the sequencer.
// master = sequencer side, slave = datapath side.
interface pipeline_hazard_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_ex_mem_read;
  logic [REG_ADDR_W-1:0] id_ex_rt;
  logic                  ex_mem_branch;
  logic                  ex_mem_zero;
  logic                  ex_mem_mem_read;
  logic                  ex_mem_mem_write;
  logic                  dmem_ready;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  pipe_enable;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  ex_mem_flush;
  logic                  pc_src;
  logic                  dmem_req;
  logic                  mem_error;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_events;

  modport master (
    input  id_rs, id_rt, id_ex_mem_read, id_ex_rt,
    input  ex_mem_branch, ex_mem_zero, ex_mem_mem_read, ex_mem_mem_write, dmem_ready,
    output pc_write, if_id_write, pipe_enable,
    output if_id_flush, id_ex_flush, ex_mem_flush,
    output pc_src, dmem_req, mem_error, stall_cycles, flush_events
  );

  modport slave (
    output id_rs, id_rt, id_ex_mem_read, id_ex_rt,
    output ex_mem_branch, ex_mem_zero, ex_mem_mem_read, ex_mem_mem_write, dmem_ready,
    input  pc_write, if_id_write, pipe_enable,
    input  if_id_flush, id_ex_flush, ex_mem_flush,
    input  pc_src, dmem_req, mem_error, stall_cycles, flush_events
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Saturating up-counter with increment enable, used for the stall / flush statistics.
module hazard_perf_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: load-use bubbles, branch redirect, data-memory freeze and timeout halt.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
//
// state    | meaning
// RUN      | normal issue; resolves memory stall, taken branch, load-use in that priority
// MEM_WAIT | data memory inserting wait states; pipeline frozen until dmem_ready
// HALT     | data-memory access timed out; pipeline frozen until reset
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  pipeline_hazard_ctrl_if.master bus
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  ctrl_state_e r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_mem_error;

  logic w_req;
  logic w_taken;
  logic w_load_use;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_pipe_enable;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_ex_mem_flush;
  logic w_pc_src;
  logic w_dmem_req;
  logic w_pc_write_o;
  logic w_pc_src_o;

  assign w_req      = bus.ex_mem_mem_read | bus.ex_mem_mem_write;
  assign w_taken    = bus.ex_mem_branch & bus.ex_mem_zero;
  assign w_load_use = load_use_hit(bus.id_ex_mem_read, bus.id_ex_rt, bus.id_rs, bus.id_rt);

  always_comb begin
    w_pc_write     = 1'b0;
    w_if_id_write  = 1'b0;
    w_pipe_enable  = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    w_pc_src       = 1'b0;
    w_dmem_req     = 1'b0;
    unique case (r_state)
      RUN: begin
        w_dmem_req = w_req;
        if (!w_req || bus.dmem_ready) begin
          w_pc_write    = 1'b1;
          w_if_id_write = 1'b1;
          w_pipe_enable = 1'b1;
          if (w_taken) begin
            w_pc_src       = 1'b1;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
          end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_flush = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        w_dmem_req = 1'b1;
        if (bus.dmem_ready) begin
          w_pc_write    = 1'b1;
          w_if_id_write = 1'b1;
          w_pipe_enable = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_mem_error <= 1'b0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_req && !bus.dmem_ready) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_ready) begin
            r_state <= RUN;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_wait_cnt == WAIT_LAST) begin
              r_state     <= HALT;
              r_mem_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= HALT;
        end
      endcase
    end
  end

  // Combinational controls are forced low while reset is held, whatever the state register shows.
  assign w_pc_write_o     = reset_n & w_pc_write;
  assign w_pc_src_o       = reset_n & w_pc_src;
  assign bus.pc_write     = w_pc_write_o;
  assign bus.if_id_write  = reset_n & w_if_id_write;
  assign bus.pipe_enable  = reset_n & w_pipe_enable;
  assign bus.if_id_flush  = reset_n & w_if_id_flush;
  assign bus.id_ex_flush  = reset_n & w_id_ex_flush;
  assign bus.ex_mem_flush = reset_n & w_ex_mem_flush;
  assign bus.pc_src       = w_pc_src_o;
  assign bus.dmem_req     = reset_n & w_dmem_req;
  assign bus.mem_error    = r_mem_error;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .i_inc   (~w_pc_write_o),
    .o_count (w_stall_cnt)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .i_inc   (w_pc_src_o),
    .o_count (w_flush_cnt)
  );

  assign bus.stall_cycles = w_stall_cnt;
  assign bus.flush_events = w_flush_cnt;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random traffic,
// compared against a cycle-level behavioural model of the sequencing rules.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic             pc_write;
    logic             if_id_write;
    logic             pipe_enable;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             pc_src;
    logic             dmem_req;
    logic             mem_error;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } out_t;

  out_t exp_q[$];
  out_t cur_exp;
  out_t mon_exp;
  out_t mon_act;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: "waiting"/"halted" flags plus a count of wait cycles spent in the access.
  bit m_waiting = 0;
  bit m_halted  = 0;
  bit m_err     = 0;
  int m_waits   = 0;
  int m_stall   = 0;
  int m_flush   = 0;

  function automatic out_t model_outputs();
    out_t o;
    bit   req, ready, taken, lu, go;
    o = '0;
    if (!reset_n) return o;
    o.mem_error = m_err;
    if (PERF) begin
      o.stall = CNT_W'(m_stall);
      o.flush = CNT_W'(m_flush);
    end
    req   = bus.ex_mem_mem_read || bus.ex_mem_mem_write;
    ready = bus.dmem_ready;
    taken = bus.ex_mem_branch && bus.ex_mem_zero;
    lu    = bus.id_ex_mem_read && (bus.id_ex_rt != 0) &&
            ((bus.id_ex_rt == bus.id_rs) || (bus.id_ex_rt == bus.id_rt));
    if (m_halted) return o;
    if (m_waiting) begin
      o.dmem_req = 1'b1;
      go = ready;
    end else begin
      o.dmem_req = req;
      go = !(req && !ready);
    end
    if (go) begin
      o.pc_write = 1; o.if_id_write = 1; o.pipe_enable = 1;
      if (!m_waiting && taken) begin
        o.pc_src = 1; o.if_id_flush = 1; o.id_ex_flush = 1; o.ex_mem_flush = 1;
      end else if (!m_waiting && lu) begin
        o.pc_write = 0; o.if_id_write = 0; o.id_ex_flush = 1;
      end
    end
    return o;
  endfunction

  task automatic model_edge(input out_t o);
    if (!reset_n) begin
      m_waiting = 0; m_halted = 0; m_err = 0; m_waits = 0; m_stall = 0; m_flush = 0;
      return;
    end
    if (!o.pc_write && m_stall < CNT_MAX) m_stall++;
    if (o.pc_src && m_flush < CNT_MAX) m_flush++;
    if (m_halted) begin
    end else if (m_waiting) begin
      if (bus.dmem_ready) m_waiting = 0;
      else begin
        m_waits++;
        if (m_waits == MEM_TIMEOUT) begin
          m_waiting = 0; m_halted = 1; m_err = 1;
        end
      end
    end else if (o.dmem_req && !bus.dmem_ready) begin
      m_waiting = 1; m_waits = 0;
    end
  endtask

  task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] ert, input logic br, input logic z,
                       input logic rd, input logic wr, input logic rdy);
    @(posedge clock);
    model_edge(cur_exp);
    #1;
    reset_n              = rst;
    bus.id_rs            = rs;
    bus.id_rt            = rt;
    bus.id_ex_mem_read   = mr;
    bus.id_ex_rt         = ert;
    bus.ex_mem_branch    = br;
    bus.ex_mem_zero      = z;
    bus.ex_mem_mem_read  = rd;
    bus.ex_mem_mem_write = wr;
    bus.dmem_ready       = rdy;
    cur_exp = model_outputs();
    exp_q.push_back(cur_exp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act.pc_write     = bus.pc_write;
        mon_act.if_id_write  = bus.if_id_write;
        mon_act.pipe_enable  = bus.pipe_enable;
        mon_act.if_id_flush  = bus.if_id_flush;
        mon_act.id_ex_flush  = bus.id_ex_flush;
        mon_act.ex_mem_flush = bus.ex_mem_flush;
        mon_act.pc_src       = bus.pc_src;
        mon_act.dmem_req     = bus.dmem_req;
        mon_act.mem_error    = bus.mem_error;
        mon_act.stall        = bus.stall_cycles;
        mon_act.flush        = bus.flush_events;
        n_vec++;
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL outputs vec %0d t=%0t: got pcw/ifw/en/flush3/src/req/err=%b stall=%0d flush=%0d, expected %b stall=%0d flush=%0d",
                   n_vec, $time, mon_act[8+2*CNT_W:2*CNT_W], mon_act.stall, mon_act.flush,
                   mon_exp[8+2*CNT_W:2*CNT_W], mon_exp.stall, mon_exp.flush);
        end
      end
    end
  end

  initial begin : stimulus
    logic rst, mr, br, z, rd, wr, rdy;
    logic [4:0] rs, rt, ert;
    cur_exp = '0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_ex_mem_read = 0; bus.id_ex_rt = 0;
    bus.ex_mem_branch = 0; bus.ex_mem_zero = 0; bus.ex_mem_mem_read = 0;
    bus.ex_mem_mem_write = 0; bus.dmem_ready = 0;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // load-use then resolved; load to r0 is harmless
    drive(1, 5, 0, 1, 5, 0, 0, 0, 0, 0);
    drive(1, 5, 0, 0, 5, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 3, 7, 1, 7, 0, 0, 0, 0, 0);
    // taken branch overriding a load-use, then untaken branch
    drive(1, 5, 0, 1, 5, 1, 1, 0, 0, 0);
    drive(1, 1, 2, 0, 0, 1, 0, 0, 0, 0);
    // memory access with 3 wait cycles, then a zero-wait write
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // timeout into HALT; ready and hazards ignored there
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < MEM_TIMEOUT; k++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    drive(1, 2, 0, 1, 2, 1, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // reset asserted in the middle of a wait
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // saturation of both counters
    for (int k = 0; k < 20; k++) drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 20; k++) drive(1, 4, 4, 1, 4, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 800; k++) begin
      rst = !((m_halted && $urandom_range(0, 2) == 0) || $urandom_range(0, 99) == 0);
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      ert = 5'($urandom_range(0, 3));
      mr  = 1'($urandom_range(0, 1));
      rd  = 0; wr = 0; br = 0;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) rd = 1; else wr = 1;
      end else if ($urandom_range(0, 3) == 0) begin
        br = 1;
      end
      // an access already in progress keeps its request in EX/MEM
      if (m_waiting) begin rd = 1; wr = 0; br = 0; end
      z   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 99) < 55);
      drive(rst, rs, rt, mr, ert, br, z, rd, wr, rdy);
    end
    idle(2);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors never checked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central sequencer for the five-stage pipeline. It drives the write-enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards and redirects fetch on a taken branch resolved in MEM. It also freezes the pipeline while the data memory inserts wait states, and halts the pipeline when a data-memory access times out.

## Interface
- MEM_TIMEOUT, 255: maximum number of wait cycles for one data-memory access before a timeout; range 1..255.
- CNT_W, 16: width of the performance counters.
- clock  in  1  rising-edge clock, named as in all pipeline registers.
- reset_n  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  source register fields of the instruction in IF/ID.
- id_ex_mem_read  in  1  MemRead of the instruction in ID/EX.
- id_ex_rt  in  5  destination register of the load in ID/EX.
- ex_mem_branch, ex_mem_zero  in  1 each  Branch_out and zero_signal_out of EX/MEM.
- ex_mem_mem_read, ex_mem_mem_write  in  1 each  MemRead_out and MemWrite_out of EX/MEM.
- dmem_ready  in  1  data memory completes the current access this cycle.
- pc_write, if_id_write  out  1 each  load enables for the PC and IF/ID.
- pipe_enable  out  1  load enable for ID/EX, EX/MEM and MEM/WB.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  synchronous clear of the register at the next edge.
- pc_src  out  1  selects the branch target (jump_dest_addr) for the next PC.
- dmem_req  out  1  data-memory request strobe.
- mem_error  out  1  sticky flag: a data-memory timeout occurred.
- stall_cycles, flush_events  out  CNT_W each  performance counters.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Reset state: RUN.
- Priority of events: memory access, then taken branch, then load-use hazard.

**RUN**
- dmem_req = ex_mem_mem_read | ex_mem_mem_write.
- Request asserted with dmem_ready=0: the whole pipeline freezes, meaning pc_write = if_id_write = pipe_enable = 0 and all flushes = 0. The FSM goes to MEM_WAIT and the wait counter is cleared.
- Request asserted with dmem_ready=1: no stall.
- Taken branch (ex_mem_branch & ex_mem_zero), which never coincides with a memory access:
  - pc_src = 1;
  - if_id_flush = id_ex_flush = ex_mem_flush = 1;
  - all enables = 1.
- Load-use hazard:
  - Condition: id_ex_mem_read & id_ex_rt != 0 & (id_ex_rt == id_rs | id_ex_rt == id_rt).
  - Response: pc_write = 0, if_id_write = 0, id_ex_flush = 1 (bubble), pipe_enable = 1.
  - A taken branch in the same cycle overrides it.
- Otherwise: all enables = 1, all flushes = 0, pc_src = 0.

**MEM_WAIT**
- dmem_req held at 1 and the pipeline stays frozen.
- The wait counter increments each cycle.
- dmem_ready=1: the freeze is released in that same cycle (enables = 1) and the FSM returns to RUN.
- Wait counter reaches MEM_TIMEOUT without dmem_ready: mem_error is set, dmem_req drops, and the FSM goes to HALT.

**HALT**
- All enables = 0, all flushes = 0, dmem_req = 0.
- The only exit is reset.

**Wait counter**
- 8 bits; does not wrap, because a timeout always occurs first.

## Timing
- All outputs except mem_error and the counters are combinational from the state and the inputs, with zero latency. Flushes and enables take effect at the next rising edge.
- The state, the wait counter, mem_error and the counters are registered.
- While reset_n is low, all enables, flushes, pc_src, dmem_req, mem_error and both counters are 0, including when reset_n goes low in MEM_WAIT or HALT.
- Reset asserts asynchronously and is released synchronously at the first edge after reset_n goes high.
- dmem_ready is ignored in RUN when no request is active and in HALT.
- A single-cycle access (ready at request) costs 0 stall cycles. An access with N wait cycles costs N stall cycles.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cycles increments on every cycle with pc_write = 0 outside reset, covering load-use, MEM_WAIT and HALT;
  - flush_events increments once per taken branch;
  - both counters saturate at 2^CNT_W-1.
- HAZARD_PERF_EN undefined: no counter registers are built and both ports are tied to 0.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, HALT);
  - REG_ADDR_W = 5;
  - the zero-register constant.
- Sub-module hazard_perf_counter: a saturating CNT_W-bit counter with increment enable. It is instantiated twice, only under HAZARD_PERF_EN.

## Test plan
- Load-use: id_ex_mem_read=1, id_ex_rt=5, id_rs=5 → pc_write=0, if_id_write=0, id_ex_flush=1 for exactly one cycle. With id_ex_rt=0 → no stall.
- Taken branch: ex_mem_branch=1, ex_mem_zero=1, with a load-use hazard present in the same cycle → pc_src=1, all three flushes=1, pc_write=1. With zero=0 → no flush.
- Memory wait: ex_mem_mem_read=1, dmem_ready low for 3 cycles → pipe frozen for 3 cycles, dmem_req high for 4 cycles, release in the cycle dmem_ready=1. With HAZARD_PERF_EN, stall_cycles = 3.
- Timeout with MEM_TIMEOUT=4: dmem_ready never asserted → FSM enters HALT after 4 wait cycles, mem_error=1, dmem_req=0, enables stay 0.
- Reset mid-wait: reset_n low during MEM_WAIT → all outputs 0 immediately. After release the FSM is in RUN and mem_error=0.
- Saturation with CNT_W=4 under HAZARD_PERF_EN: 20 taken branches → flush_events holds at 15.
